// File: rtl/transmit_frame_shaper.sv
// rtl/transmit_frame_shaper.sv - byte-stream frame shaper for a transmit MAC
// Pads short frames, truncates long ones, discards after underrun and enforces the inter-frame gap.
module transmit_frame_shaper #(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pkt_valid,
  input  logic [7:0]  iv_pkt_data,
  input  logic        i_pkt_last,
  output logic        o_pkt_ready,
  output logic        o_data_wr,
  output logic [7:0]  ov_data,
  output logic        o_frame_done,
  output logic        o_underrun,
  output logic        o_oversize,
  output logic [15:0] ov_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XMIT,
    S_PAD,
    S_DISCARD,
    S_IFG
  } state_t;

  localparam int              IW       = $clog2(IFG_CYCLES + 1);
  localparam logic [IW-1:0]   IFG_LAST = IW'(IFG_CYCLES - 1);
  localparam logic [10:0]     MIN_C    = 11'(MIN_LEN);
  localparam logic [10:0]     MAX_C    = 11'(MAX_LEN);

  state_t        state;
  logic [10:0]   cnt;
  logic [IW-1:0] ifg_cnt;
  logic          discard_pend;
  logic          xfer;
  logic [10:0]   next_cnt;

  assign o_pkt_ready = i_rst_n && (state == S_IDLE || state == S_XMIT || state == S_DISCARD);
  assign xfer        = i_pkt_valid && o_pkt_ready;
  assign next_cnt    = (state == S_IDLE) ? 11'd1 : cnt + 11'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ifg_cnt      <= '0;
      discard_pend <= 1'b0;
      o_data_wr    <= 1'b0;
      ov_data      <= 8'h00;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
      o_oversize   <= 1'b0;
      ov_frame_cnt <= 16'h0000;
    end else begin
      o_data_wr    <= 1'b0;
      ov_data      <= 8'h00;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
      o_oversize   <= 1'b0;
      case (state)
        S_IDLE, S_XMIT: begin
          if (xfer) begin
            o_data_wr <= 1'b1;
            ov_data   <= iv_pkt_data;
            cnt       <= next_cnt;
            if (i_pkt_last) begin
              if (next_cnt >= MIN_C) begin
                o_frame_done <= 1'b1;
                ov_frame_cnt <= ov_frame_cnt + 16'd1;
                ifg_cnt      <= '0;
                state        <= S_IFG;
              end else begin
                state <= S_PAD;
              end
            end else if (next_cnt == MAX_C) begin
              o_frame_done <= 1'b1;
              o_oversize   <= 1'b1;
              ov_frame_cnt <= ov_frame_cnt + 16'd1;
              ifg_cnt      <= '0;
              state        <= S_DISCARD;
            end else begin
              state <= S_XMIT;
            end
          end else if (state == S_XMIT) begin
            // Stall mid-frame: a pad byte goes out this very cycle so the strobe never gaps.
            o_underrun <= 1'b1;
            o_data_wr  <= 1'b1;
            cnt        <= next_cnt;
            if (next_cnt >= MIN_C) begin
              o_frame_done <= 1'b1;
              ov_frame_cnt <= ov_frame_cnt + 16'd1;
              ifg_cnt      <= '0;
              state        <= S_DISCARD;
            end else begin
              discard_pend <= 1'b1;
              state        <= S_PAD;
            end
          end
        end
        S_PAD: begin
          o_data_wr <= 1'b1;
          cnt       <= next_cnt;
          if (next_cnt == MIN_C) begin
            o_frame_done <= 1'b1;
            ov_frame_cnt <= ov_frame_cnt + 16'd1;
            ifg_cnt      <= '0;
            discard_pend <= 1'b0;
            state        <= discard_pend ? S_DISCARD : S_IFG;
          end
        end
        S_DISCARD: begin
          // The gap timer already runs here so discard time counts toward the IFG.
          if (ifg_cnt != IFG_LAST) begin
            ifg_cnt <= ifg_cnt + IW'(1);
          end
          if (xfer && i_pkt_last) begin
            state <= S_IFG;
          end
        end
        S_IFG: begin
          if (ifg_cnt >= IFG_LAST) begin
            ifg_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transmit_frame_shaper.sv
// tb/tb_transmit_frame_shaper.sv - directed self-checking bench for transmit_frame_shaper
// A negedge monitor collects emitted frames; the main sequence checks them with immediate assertions.
module tb_transmit_frame_shaper;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pkt_valid;
  logic [7:0]  iv_pkt_data;
  logic        i_pkt_last;
  logic        o_pkt_ready;
  logic        o_data_wr;
  logic [7:0]  ov_data;
  logic        o_frame_done;
  logic        o_underrun;
  logic        o_oversize;
  logic [15:0] ov_frame_cnt;

  always #5 i_clk = ~i_clk;

  transmit_frame_shaper dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pkt_valid  (i_pkt_valid),
    .iv_pkt_data  (iv_pkt_data),
    .i_pkt_last   (i_pkt_last),
    .o_pkt_ready  (o_pkt_ready),
    .o_data_wr    (o_data_wr),
    .ov_data      (ov_data),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun),
    .o_oversize   (o_oversize),
    .ov_frame_cnt (ov_frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor state
  logic [7:0] fb [0:15][0:1599];
  int flen [0:15];
  int fgap [0:15];
  int frdy [0:15];
  int fstart [0:15];
  int fcnt_at [0:15];
  int over_pos [0:15];
  int under_pos [0:15];
  int nfr = 0, cur = 0, in_frame = 0, idle = 0, rdy_gap = 0;
  int holes = 0, nonzero_idle = 0, under_total = 0, over_total = 0, stray_done = 0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      in_frame = 0;
      cur = 0;
      idle = 0;
      rdy_gap = 0;
    end else if (o_data_wr) begin
      if (!in_frame && nfr < 16) begin
        fgap[nfr] = idle;
        frdy[nfr] = rdy_gap;
        fstart[nfr] = cyc;
        over_pos[nfr] = 0;
        under_pos[nfr] = 0;
        in_frame = 1;
        cur = 0;
      end
      if (nfr < 16 && cur < 1600) fb[nfr][cur] = ov_data;
      if (o_oversize) begin over_total++; if (nfr < 16) over_pos[nfr] = cur + 1; end
      if (o_underrun) begin under_total++; if (nfr < 16) under_pos[nfr] = cur + 1; end
      cur++;
      if (o_frame_done) begin
        if (nfr < 16) begin flen[nfr] = cur; fcnt_at[nfr] = int'(ov_frame_cnt); end
        nfr++;
        in_frame = 0;
        idle = 0;
        rdy_gap = 0;
      end
    end else begin
      if (in_frame) holes++;
      if (ov_data != 8'h00) nonzero_idle++;
      if (o_frame_done || o_underrun || o_oversize) stray_done++;
      idle++;
      if (o_pkt_ready) rdy_gap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bad_bytes(input int f, input int n, input int base, input int data_n);
    int bad = 0;
    for (int j = 0; j < n; j++) begin
      logic [7:0] e;
      e = (j < data_n) ? 8'((base + j) & 255) : 8'h00;
      if (fb[f][j] !== e) bad++;
    end
    return bad;
  endfunction

  int first_xfer = 0;

  // Sends len bytes valued base+i; optional stall of stall_len cycles after stall_after bytes;
  // stop_after>0 abandons the frame after that many bytes without a last.
  task automatic send(input string tag, input int len, input int base,
                      input int stall_after, input int stall_len, input int stop_after);
    int i = 0;
    int wait_cnt = 0;
    int sl = stall_len;
    logic acc;
    logic timed_out = 1'b0;
    while (i < len && !(stop_after > 0 && i == stop_after)) begin
      if (stall_after > 0 && i == stall_after && sl > 0) begin
        i_pkt_valid = 1'b0;
        i_pkt_last  = 1'b0;
        repeat (sl) @(posedge i_clk);
        #1;
        sl = 0;
      end
      i_pkt_valid = 1'b1;
      iv_pkt_data = 8'((base + i) & 255);
      i_pkt_last  = (i == len - 1);
      @(negedge i_clk);
      acc = o_pkt_ready;
      if (acc && i == 0) first_xfer = cyc;
      @(posedge i_clk);
      #1;
      if (acc) i++;
      else begin
        wait_cnt++;
        if (wait_cnt > 5000) begin timed_out = 1'b1; break; end
      end
    end
    i_pkt_valid = 1'b0;
    i_pkt_last  = 1'b0;
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    i_pkt_valid = 1'b0;
    iv_pkt_data = 8'h00;
    i_pkt_last = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_data_wr", 32'(o_data_wr), 32'd0);
    check("rst_ov_data", 32'(ov_data), 32'd0);
    check("rst_frame_done", 32'(o_frame_done), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    check("rst_oversize", 32'(o_oversize), 32'd0);
    check("rst_frame_cnt", 32'(ov_frame_cnt), 32'd0);
    check("rst_ready", 32'(o_pkt_ready), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_release", 32'(o_pkt_ready), 32'd1);
    @(posedge i_clk); #1;

    // 100-byte frame 0x00..0x63
    send("f100", 100, 0, 0, 0, 0);
    repeat (40) @(posedge i_clk); #1;
    check("f100_nfr", 32'(nfr), 32'd1);
    check("f100_len", 32'(flen[0]), 32'd100);
    check("f100_bytes", 32'(bad_bytes(0, 100, 0, 100)), 32'd0);
    check("f100_latency", 32'(fstart[0] - first_xfer), 32'd1);
    check("f100_fcnt", 32'(fcnt_at[0]), 32'd1);
    check("f100_live_fcnt", 32'(ov_frame_cnt), 32'd1);

    // 10-byte frame padded to 60
    send("f10", 10, 8'hA0, 0, 0, 0);
    repeat (90) @(posedge i_clk); #1;
    check("f10_len", 32'(flen[1]), 32'd60);
    check("f10_bytes", 32'(bad_bytes(1, 60, 8'hA0, 10)), 32'd0);
    check("f10_fcnt", 32'(fcnt_at[1]), 32'd2);

    // Back-to-back 64-byte frames, valid held high
    send("b2b_a", 64, 8'h10, 0, 0, 0);
    send("b2b_b", 64, 8'h50, 0, 0, 0);
    repeat (40) @(posedge i_clk); #1;
    check("b2b_a_len", 32'(flen[2]), 32'd64);
    check("b2b_b_len", 32'(flen[3]), 32'd64);
    check("b2b_b_bytes", 32'(bad_bytes(3, 64, 8'h50, 64)), 32'd0);
    check("b2b_gap", 32'(fgap[3]), 32'd20);
    check("b2b_gap_ready_cycles", 32'(frdy[3]), 32'd1);
    check("b2b_fcnt", 32'(fcnt_at[3]), 32'd4);

    // 1600-byte frame truncated at 1514
    send("over", 1600, 0, 0, 0, 0);
    repeat (40) @(posedge i_clk); #1;
    check("over_nfr", 32'(nfr), 32'd5);
    check("over_len", 32'(flen[4]), 32'd1514);
    check("over_pos", 32'(over_pos[4]), 32'd1514);
    check("over_total", 32'(over_total), 32'd1);
    check("over_bytes", 32'(bad_bytes(4, 1514, 0, 1514)), 32'd0);
    check("over_fcnt", 32'(fcnt_at[4]), 32'd5);

    // Underrun after byte 30, last at byte 40
    send("under", 40, 8'h40, 30, 5, 0);
    repeat (60) @(posedge i_clk); #1;
    check("under_nfr", 32'(nfr), 32'd6);
    check("under_len", 32'(flen[5]), 32'd60);
    check("under_pos", 32'(under_pos[5]), 32'd31);
    check("under_total", 32'(under_total), 32'd1);
    check("under_bytes", 32'(bad_bytes(5, 60, 8'h40, 30)), 32'd0);
    check("under_fcnt", 32'(fcnt_at[5]), 32'd6);

    // Reset pulsed at byte 25 of a frame
    send("rst_mid", 60, 8'h20, 0, 0, 25);
    check("pre_reset_wr", 32'(o_data_wr), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("async_reset_wr", 32'(o_data_wr), 32'd0);
    check("async_reset_fcnt", 32'(ov_frame_cnt), 32'd0);
    check("async_reset_ready", 32'(o_pkt_ready), 32'd0);
    repeat (3) @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    send("post_rst", 64, 8'h80, 0, 0, 0);
    repeat (40) @(posedge i_clk); #1;
    check("post_rst_nfr", 32'(nfr), 32'd7);
    check("post_rst_len", 32'(flen[6]), 32'd64);
    check("post_rst_bytes", 32'(bad_bytes(6, 64, 8'h80, 64)), 32'd0);
    check("post_rst_latency", 32'(fstart[6] - first_xfer), 32'd1);
    check("post_rst_fcnt", 32'(fcnt_at[6]), 32'd1);

    // Whole-run invariants
    check("holes_in_frames", 32'(holes), 32'd0);
    check("nonzero_idle_data", 32'(nonzero_idle), 32'd0);
    check("pulses_without_wr", 32'(stray_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
